morse_encoder: RTL and testbench

//  Transmit side of the Morse symbol link. Accepts one ASCII character per

---
 rtl/morse_encoder_if.sv | 10 +
 rtl/morse_encoder.sv | 217 +++++++++++++++++++++
 tb/tb_morse_encoder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/morse_encoder_if.sv
// Character channel into the Morse encoder: one ASCII byte per valid/ready handshake.
`timescale 1ns/1ps
interface morse_encoder_if;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;

  modport master (output char_in, output char_valid, input char_ready);
  modport slave  (input char_in, input char_valid, output char_ready);
endinterface

// File: rtl/morse_encoder.sv
// ASCII-to-Morse encoder that emits one-cycle dot/dash/char_space/word_space strobes.
// Optional macro MORSE_LOWER_EN folds lower-case a-z onto A-Z before lookup.
`timescale 1ns/1ps
module morse_encoder #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  morse_encoder_if.slave   chr,
  output logic             dot_inp,
  output logic             dash_inp,
  output logic             char_space_inp,
  output logic             word_space_inp,
  output logic             err_out,
  output logic             busy
);

  localparam int CNT_W = (UNIT_CYCLES < 2) ? 1 : $clog2(UNIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP2_LAST = CNT_W'(UNIT_CYCLES);

  typedef enum logic [2:0] {IDLE, SYM, GAP, CSP, WSP, GAP2, ERR} state_e;

  typedef struct packed {
    logic       sup;
    logic       space;
    logic [2:0] len;
    logic [4:0] pat;
  } code_t;

  // pat is right-aligned: bit len-1 goes out first, 1 = dash
  function automatic code_t lookup(input logic [7:0] c);
    code_t      r;
    logic [7:0] ch;
    ch = c;
`ifdef MORSE_LOWER_EN
    if (c >= 8'h61 && c <= 8'h7A) begin
      ch = c - 8'h20;
    end else begin
      ch = c;
    end
`endif
    r.sup   = 1'b1;
    r.space = 1'b0;
    r.len   = 3'd0;
    r.pat   = 5'b00000;
    case (ch)
      8'h41: {r.len, r.pat} = {3'd2, 5'b00001};
      8'h42: {r.len, r.pat} = {3'd4, 5'b01000};
      8'h43: {r.len, r.pat} = {3'd4, 5'b01010};
      8'h44: {r.len, r.pat} = {3'd3, 5'b00100};
      8'h45: {r.len, r.pat} = {3'd1, 5'b00000};
      8'h46: {r.len, r.pat} = {3'd4, 5'b00010};
      8'h47: {r.len, r.pat} = {3'd3, 5'b00110};
      8'h48: {r.len, r.pat} = {3'd4, 5'b00000};
      8'h49: {r.len, r.pat} = {3'd2, 5'b00000};
      8'h4A: {r.len, r.pat} = {3'd4, 5'b00111};
      8'h4B: {r.len, r.pat} = {3'd3, 5'b00101};
      8'h4C: {r.len, r.pat} = {3'd4, 5'b00100};
      8'h4D: {r.len, r.pat} = {3'd2, 5'b00011};
      8'h4E: {r.len, r.pat} = {3'd2, 5'b00010};
      8'h4F: {r.len, r.pat} = {3'd3, 5'b00111};
      8'h50: {r.len, r.pat} = {3'd4, 5'b00110};
      8'h51: {r.len, r.pat} = {3'd4, 5'b01101};
      8'h52: {r.len, r.pat} = {3'd3, 5'b00010};
      8'h53: {r.len, r.pat} = {3'd3, 5'b00000};
      8'h54: {r.len, r.pat} = {3'd1, 5'b00001};
      8'h55: {r.len, r.pat} = {3'd3, 5'b00001};
      8'h56: {r.len, r.pat} = {3'd4, 5'b00001};
      8'h57: {r.len, r.pat} = {3'd3, 5'b00011};
      8'h58: {r.len, r.pat} = {3'd4, 5'b01001};
      8'h59: {r.len, r.pat} = {3'd4, 5'b01011};
      8'h5A: {r.len, r.pat} = {3'd4, 5'b01100};
      8'h30: {r.len, r.pat} = {3'd5, 5'b11111};
      8'h31: {r.len, r.pat} = {3'd5, 5'b01111};
      8'h32: {r.len, r.pat} = {3'd5, 5'b00111};
      8'h33: {r.len, r.pat} = {3'd5, 5'b00011};
      8'h34: {r.len, r.pat} = {3'd5, 5'b00001};
      8'h35: {r.len, r.pat} = {3'd5, 5'b00000};
      8'h36: {r.len, r.pat} = {3'd5, 5'b10000};
      8'h37: {r.len, r.pat} = {3'd5, 5'b11000};
      8'h38: {r.len, r.pat} = {3'd5, 5'b11100};
      8'h39: {r.len, r.pat} = {3'd5, 5'b11110};
      8'h20: r.space = 1'b1;
      default: r.sup = 1'b0;
    endcase
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [4:0]       pat_q, pat_d;
  logic             dot_q, dot_d;
  logic             dash_q, dash_d;
  logic             csp_q, csp_d;
  logic             wsp_q, wsp_d;
  logic             err_q, err_d;
  code_t            lut_s;

  assign lut_s          = lookup(chr.char_in);
  assign chr.char_ready = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign dot_inp        = dot_q;
  assign dash_inp       = dash_q;
  assign char_space_inp = csp_q;
  assign word_space_inp = wsp_q;
  assign err_out        = err_q;

  // Next-state and strobe decode; strobes are registered so they appear one cycle after the state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    dot_d   = 1'b0;
    dash_d  = 1'b0;
    csp_d   = 1'b0;
    wsp_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (chr.char_valid) begin
          if (lut_s.space) begin
            state_d = WSP;
          end else if (lut_s.sup) begin
            pat_d   = lut_s.pat;
            idx_d   = lut_s.len - 3'd1;
            state_d = SYM;
          end else begin
            state_d = ERR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SYM: begin
        dash_d  = pat_q[idx_q];
        dot_d   = ~pat_q[idx_q];
        cnt_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q == 3'd0) begin
            state_d = CSP;
          end else begin
            idx_d   = idx_q - 3'd1;
            state_d = SYM;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CSP: begin
        csp_d   = 1'b1;
        cnt_d   = '0;
        state_d = GAP2;
      end
      WSP: begin
        wsp_d   = 1'b1;
        cnt_d   = '0;
        state_d = GAP2;
      end
      // one extra count here covers the registered-output cycle of the final strobe
      GAP2: begin
        if (cnt_q == GAP2_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ERR: begin
        err_d = (cnt_q == '0);
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered strobes; reset discards any in-flight character
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      pat_q   <= 5'b00000;
      dot_q   <= 1'b0;
      dash_q  <= 1'b0;
      csp_q   <= 1'b0;
      wsp_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      dot_q   <= dot_d;
      dash_q  <= dash_d;
      csp_q   <= csp_d;
      wsp_q   <= wsp_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_morse_encoder.sv
// Scoreboard bench for morse_encoder: stimulus queues expected strobes and ready times, a monitor checks them.
`timescale 1ns/1ps
module tb_morse_encoder;
  localparam int U = 4;
  localparam int K_DOT = 1, K_DASH = 2, K_CSP = 3, K_WSP = 4, K_ERR = 5;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dot_inp, dash_inp, char_space_inp, word_space_inp, err_out, busy;
  int   cyc = 0;
  bit   done = 1'b0;
  int   checks = 0;
  int   errors = 0;
  ev_t  ev_q[$];
  int   rdy_q[$];

  morse_encoder_if iface();

  morse_encoder #(.UNIT_CYCLES(U)) dut (
    .clk            (clk),
    .rst            (rst_n),
    .chr            (iface),
    .dot_inp        (dot_inp),
    .dash_inp       (dash_inp),
    .char_space_inp (char_space_inp),
    .word_space_inp (word_space_inp),
    .err_out        (err_out),
    .busy           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every strobe and every ready rising edge against the queued expectations
  always @(negedge clk) begin : monitor
    int  act;
    int  kind;
    ev_t e;
    int  r;
    bit  prev_any;
    bit  prev_ready;
    act = int'(dot_inp) + int'(dash_inp) + int'(char_space_inp) + int'(word_space_inp) + int'(err_out);
    if (!rst_n) begin
      checks++;
      if (act != 0 || iface.char_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: active=%0d ready=%b busy=%b, required 0/1/0", act, iface.char_ready, busy);
      end
      ev_q.delete();
      rdy_q.delete();
      prev_any   = 1'b0;
      prev_ready = iface.char_ready;
    end else begin
      if (act > 0) begin
        kind = dot_inp ? K_DOT : dash_inp ? K_DASH : char_space_inp ? K_CSP : word_space_inp ? K_WSP : K_ERR;
        checks++;
        if (act > 1 || prev_any) begin
          errors++;
          $display("FAIL strobe_exclusive: cycle %0d active=%0d prev_active=%b, required 1/0", cyc, act, prev_any);
        end
        checks++;
        if (ev_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: cycle %0d kind %0d, required none", cyc, kind);
        end else begin
          e = ev_q.pop_front();
          if (e.kind != kind || e.cyc != cyc) begin
            errors++;
            $display("FAIL strobe: got kind %0d at cycle %0d, required kind %0d at cycle %0d", kind, cyc, e.kind, e.cyc);
          end
        end
      end
      if (iface.char_ready && !prev_ready) begin
        checks++;
        if (rdy_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready: cycle %0d", cyc);
        end else begin
          r = rdy_q.pop_front();
          if (r != cyc) begin
            errors++;
            $display("FAIL ready_time: ready at cycle %0d, required cycle %0d", cyc, r);
          end
        end
      end
      checks++;
      if (busy !== ~iface.char_ready) begin
        errors++;
        $display("FAIL busy_vs_ready: busy=%b ready=%b, required busy=~ready", busy, iface.char_ready);
      end
      prev_any   = (act > 0);
      prev_ready = iface.char_ready;
    end
    if (done) begin
      checks++;
      if (ev_q.size() != 0 || rdy_q.size() != 0) begin
        errors++;
        $display("FAIL leftover: %0d strobes and %0d ready edges never seen, required 0", ev_q.size(), rdy_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  // Handshake one character and queue what must follow it; returns at the negedge after the accept edge
  task automatic start(input logic [7:0] c, input string code, input int kind);
    int k;
    @(negedge clk);
    iface.char_in    = c;
    iface.char_valid = 1'b1;
    @(negedge clk);
    k = cyc;
    iface.char_valid = 1'b0;
    if (kind == K_WSP) begin
      ev_q.push_back('{K_WSP, k + 1});
      rdy_q.push_back(k + U + 2);
    end else if (kind == K_ERR) begin
      ev_q.push_back('{K_ERR, k + 1});
      rdy_q.push_back(k + 2);
    end else begin
      for (int i = 0; i < code.len(); i++) begin
        ev_q.push_back('{(code[i] == "-") ? K_DASH : K_DOT, k + 1 + i * (U + 1)});
      end
      ev_q.push_back('{K_CSP, k + 1 + code.len() * (U + 1)});
      rdy_q.push_back(k + (code.len() + 1) * (U + 1) + 1);
    end
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (iface.char_ready) return;
    end
    $display("FAIL ready_timeout: char_ready stayed 0 for 300 cycles, required 1");
    $fatal(1);
  endtask

  task automatic send(input logic [7:0] c, input string code, input int kind);
    start(c, code, kind);
    wait_ready();
  endtask

  initial begin
    iface.char_in    = 8'h00;
    iface.char_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(8'h45, ".", 0);
    send(8'h30, "-----", 0);
    send(8'h20, "", K_WSP);
    send(8'h23, "", K_ERR);
    send(8'h35, ".....", 0);
    send(8'h5A, "--..", 0);
`ifdef MORSE_LOWER_EN
    send(8'h61, ".-", 0);
`else
    send(8'h61, "", K_ERR);
`endif
    send(8'h7B, "", K_ERR);

    // valid held with another character while busy must not be taken
    start(8'h4B, "-.-", 0);
    iface.char_in    = 8'h45;
    iface.char_valid = 1'b1;
    repeat (5) @(negedge clk);
    iface.char_valid = 1'b0;
    wait_ready();

    // reset after the second strobe of 'Q' discards the rest of it
    start(8'h51, "--.-", 0);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(8'h54, "-", 0);

    repeat (3) @(negedge clk);
    done = 1'b1;
    repeat (10) @(negedge clk);
    $display("FAIL monitor_stall: summary not reached");
    $fatal(1);
  end

endmodule
